async_fifo_read_sched: RTL
==========================

# async_fifo_read_sched

Read-side scheduler for the asynchronous FIFO read channel: shares one FIFO read port among `NUM_REQ` consumers in the read clock domain. It arbitrates round-robin, holds a grant for a burst of up to `MAX_BURST` pops, drives `read_fifo_pop` and returns each popped word tagged with the owning requester's ID. It sits between the FIFO read port (driver side) and the downstream consumers.

## Interface
Parameters:
- `FIFO_DATA_WIDTH`, 32, width of `read_data` / `rsp_data`
- `NUM_REQ`, 4, number of requesters (≥2)
- `MAX_BURST`, 8, maximum pops per grant (≥1)

Derived widths:
- `ID_W` = max(1, $clog2(`NUM_REQ`))
- `BC_W` = $clog2(`MAX_BURST`+1)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `read_clk`  in  1  read-domain clock
- `read_reset`  in  1  synchronous, active-high reset
- `req`  in  `NUM_REQ`  per-requester level request
- `gnt`  out  `NUM_REQ`  one-hot grant, registered
- `read_fifo_pop`  out  1  pop strobe to FIFO
- `read_fifo_empty`  in  1  FIFO empty flag
- `read_data`  in  `FIFO_DATA_WIDTH`  FIFO read data, valid the cycle after a pop
- `rsp_valid`  out  1  response word valid, registered
- `rsp_data`  out  `FIFO_DATA_WIDTH`  response word, registered
- `rsp_id`  out  `ID_W`  requester index owning `rsp_data`

## Operation
- FSM states: IDLE, BURST.
- IDLE
  - If any `req` is set, pick the first set bit at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - Register `gnt` (one-hot) and `gnt_id`, clear `beat_cnt`, go to BURST.
  - With no request, stay in IDLE; `gnt` = 0.
- BURST
  - `read_fifo_pop` = `req[gnt_id]` & ~`read_fifo_empty` & (`beat_cnt` < `MAX_BURST`). This is combinational; it is never asserted outside BURST.
  - Each pop increments `beat_cnt`.
  - Leave to IDLE when `req[gnt_id]` is low, or when a pop makes `beat_cnt` reach `MAX_BURST`.
  - On exit: `gnt` clears and `rr_ptr` ← (`gnt_id`+1) mod `NUM_REQ`, computed without overflow for non-power-of-2 `NUM_REQ`.
- FIFO empty while in BURST: no pop, grant retained, `beat_cnt` unchanged (stall). The requester may drop `req` to release the grant.
- Response pipeline
  - Stage `pop_d1`/`id_d1` registers the pop and `gnt_id`.
  - In the cycle `pop_d1` is high, `read_data` is sampled into `rsp_data`, `rsp_id` ← `id_d1`, and `rsp_valid` ← 1.
  - No backpressure: responses are never stalled or dropped.
- Requests arriving while another requester holds the grant wait until the next IDLE cycle.
- Reset values: `gnt` = 0, `read_fifo_pop` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, state = IDLE, `rr_ptr` = 0, `beat_cnt` = 0, `pop_d1` = 0.
- Reset mid-burst: grant dropped and in-flight words discarded. Words already popped are lost; this is by design.

## Timing
- `req` rises in cycle 0 (IDLE) → `gnt` high in cycle 1 → first pop in cycle 1 (if not empty) → `read_data` in cycle 2 → `rsp_valid` in cycle 3.
- Pop-to-response latency is 2 cycles. Sustained throughput is 1 word per cycle within a burst.
- At least one IDLE (arbitration) cycle separates consecutive grants, including re-grant to the same requester.
- A pop in the final BURST cycle still produces its response 2 cycles later, after `gnt` has dropped. `rsp_id` identifies the owner.
- `req` deassertion in cycle c suppresses the pop in cycle c (combinational) and exits the burst at the end of cycle c.

## Configuration
- `ASYNC_FIFO_READ_SCHED_STATS_EN` defined:
  - Adds output `pop_count` [31:0]: total pops since reset.
  - Increments on each `read_fifo_pop`, wraps 0xFFFF_FFFF→0, reset value 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Single requester, FIFO holding 3 words (A,B,C), `req[0]` held → `gnt`=0001 in cycle 1, pops in cycles 1-3, responses A,B,C with `rsp_id`=0 in cycles 3-5, FIFO then empty → grant held with no pop.
- All 4 `req` held, FIFO never empty, `MAX_BURST`=8 → grants 0,1,2,3,0 in order, exactly 8 pops each, one idle cycle between grants, 8 responses per ID.
- `req[2]` drops after 3 pops while `req[1]` is held → 3 responses with ID 2, then IDLE, then `gnt`=0010 (pointer at 3 wraps to 1).
- FIFO empty for 4 cycles mid-burst → `read_fifo_pop`=0 for those cycles, `gnt` unchanged, `beat_cnt` frozen; the burst resumes and totals `MAX_BURST` pops.
- Reset asserted one cycle after a pop → next cycle `gnt`=0, `rsp_valid`=0, `pop_d1`=0; first grant after release goes to the lowest set `req` at or after index 0.
- With `ASYNC_FIFO_READ_SCHED_STATS_EN`: preload `pop_count` to 0xFFFF_FFFE via 2^32-2 pops (or force), do 3 pops → reads 0x0000_0001.

Source files
------------

// File: rtl/async_fifo_read_sched.sv
// -----------------------------------------------------------------------------
// async_fifo_read_sched
//
// Read-side scheduler for an asynchronous FIFO read channel. Shares the single
// FIFO read port among NUM_REQ consumers in the read clock domain:
//   - round-robin arbitration in an IDLE cycle, starting at rr_ptr
//   - the grant is held for a burst of up to MAX_BURST pops
//   - each popped word is returned two cycles after its pop, tagged with the
//     index of the requester that owned the grant when it was popped
//
// Parameters:
//   FIFO_DATA_WIDTH  width of read_data / rsp_data
//   NUM_REQ          number of requesters (>= 2)
//   MAX_BURST        maximum pops per grant (>= 1)
//
// Ports:
//   read_clk         read-domain clock
//   read_reset       synchronous, active-high reset
//   req              per-requester level request
//   gnt              one-hot grant (registered)
//   read_fifo_pop    pop strobe to the FIFO (combinational, BURST only)
//   read_fifo_empty  FIFO empty flag
//   read_data        FIFO read data, valid the cycle after a pop
//   rsp_valid        response word valid (registered)
//   rsp_data         response word (registered)
//   rsp_id           requester index owning rsp_data (registered)
//   pop_count        total pops since reset, wrapping (only when the
//                    ASYNC_FIFO_READ_SCHED_STATS_EN macro is defined)
//
// Optional feature macro: ASYNC_FIFO_READ_SCHED_STATS_EN
// -----------------------------------------------------------------------------
module async_fifo_read_sched #(
    parameter int unsigned FIFO_DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned MAX_BURST       = 8,
    localparam int unsigned ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned BC_W           = $clog2(MAX_BURST + 1)
) (
    input  logic                       read_clk,
    input  logic                       read_reset,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       read_fifo_pop,
    input  logic                       read_fifo_empty,
    input  logic [FIFO_DATA_WIDTH-1:0] read_data,
    output logic                       rsp_valid,
    output logic [FIFO_DATA_WIDTH-1:0] rsp_data,
    output logic [ID_W-1:0]            rsp_id
`ifdef ASYNC_FIFO_READ_SCHED_STATS_EN
    ,
    output logic [31:0]                pop_count
`endif
);

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e                     state_q, state_d;
    logic [NUM_REQ-1:0]         gnt_q, gnt_d;
    logic [ID_W-1:0]            gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]            beat_cnt_q, beat_cnt_d;

    logic                       pop_d1_q, pop_d1_d;
    logic [ID_W-1:0]            id_d1_q, id_d1_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [FIFO_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]            rsp_id_q, rsp_id_d;

    // -------------------------------------------------------------------------
    // Round-robin pick: first set request at or after rr_ptr, wrapping.
    // The index is folded back by subtraction so non-power-of-2 NUM_REQ
    // never produces an out-of-range requester.
    // -------------------------------------------------------------------------
    logic            arb_found;
    logic [ID_W-1:0] arb_id;

    always_comb begin
        int unsigned idx;
        arb_found = 1'b0;
        arb_id    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!arb_found && req[ID_W'(idx)]) begin
                arb_found = 1'b1;
                arb_id    = ID_W'(idx);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pop strobe. Reset also gates the strobe so no word is pulled from the
    // FIFO in a cycle whose response pipeline is being cleared.
    // -------------------------------------------------------------------------
    logic owner_req;
    logic beats_left;
    logic last_beat;
    logic pop;

    assign owner_req  = req[gnt_id_q];
    assign beats_left = (beat_cnt_q < BC_W'(MAX_BURST));
    assign last_beat  = (beat_cnt_q == BC_W'(MAX_BURST - 1));
    assign pop        = (state_q == StBurst) && owner_req && !read_fifo_empty
                        && beats_left && !read_reset;

    // Next round-robin pointer after the current owner, wrap without overflow.
    logic [ID_W-1:0] next_ptr;
    assign next_ptr = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + ID_W'(1);

    // -------------------------------------------------------------------------
    // FSM next state and grant bookkeeping
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;

        unique case (state_q)
            StIdle: begin
                gnt_d = '0;
                if (arb_found) begin
                    gnt_d      = NUM_REQ'(1) << arb_id;
                    gnt_id_d   = arb_id;
                    beat_cnt_d = '0;
                    state_d    = StBurst;
                end
            end
            StBurst: begin
                if (pop) begin
                    beat_cnt_d = beat_cnt_q + BC_W'(1);
                end
                // Empty FIFO only stalls; dropping req or the final beat releases.
                if (!owner_req || (pop && last_beat)) begin
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Response pipeline: pop -> (pop_d1, id_d1) -> sample read_data -> rsp
    // -------------------------------------------------------------------------
    always_comb begin
        pop_d1_d    = pop;
        id_d1_d     = gnt_id_q;
        rsp_valid_d = pop_d1_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (pop_d1_q) begin
            rsp_data_d = read_data;
            rsp_id_d   = id_d1_q;
        end
    end

    always_ff @(posedge read_clk) begin
        if (read_reset) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            pop_d1_q    <= 1'b0;
            id_d1_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            pop_d1_q    <= pop_d1_d;
            id_d1_q     <= id_d1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign gnt           = gnt_q;
    assign read_fifo_pop = pop;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_id        = rsp_id_q;

    // -------------------------------------------------------------------------
    // Optional pop statistics
    // -------------------------------------------------------------------------
`ifdef ASYNC_FIFO_READ_SCHED_STATS_EN
    logic [31:0] pop_count_q, pop_count_d;

    always_comb begin
        pop_count_d = pop_count_q;
        if (pop) begin
            pop_count_d = pop_count_q + 32'd1;
        end
    end

    always_ff @(posedge read_clk) begin
        if (read_reset) begin
            pop_count_q <= '0;
        end else begin
            pop_count_q <= pop_count_d;
        end
    end

    assign pop_count = pop_count_q;
`else
    // Statistics counter not built.
`endif

endmodule
